w0rm_peripheral_irq_arbiter: RTL and testbench

//  Peripheral-side source of the core interrupt interface. Collects per-peripheral IRQ lines,

---
 rtl/w0rm_peripheral_irq_arbiter_pkg.sv | 18 +
 rtl/w0rm_peripheral_irq_arbiter_if.sv | 30 +++
 rtl/w0rm_peripheral_irq_arbiter_priority_encoder.sv | 24 ++
 rtl/w0rm_peripheral_irq_arbiter.sv | 145 ++++++++++++++
 tb/tb_w0rm_peripheral_irq_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/w0rm_peripheral_irq_arbiter_pkg.sv
// Shared types and constants for the peripheral interrupt arbiter.
// The core controller owns vector 0; peripheral vectors start above it.
package w0rm_irq_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE       = 2'd0,
    IRQ_REQUEST    = 2'd1,
    IRQ_IN_SERVICE = 2'd2
  } irq_state_e;

  localparam int CORE_ISR_VECTOR = 0;

  // Index width for a source count; a single source still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/w0rm_peripheral_irq_arbiter_if.sv
// Bundle of IRQ lines, configuration strobes and the core controller handshake.
// The arbiter is the slave side; the SoC / controller side is the master.
interface w0rm_peripheral_irq_arbiter_if #(
  parameter int NUM_SOURCES = 8,
  parameter int ISR_WIDTH   = 8
);

  logic [NUM_SOURCES-1:0] irq_in;
  logic                   cfg_enable_we;
  logic [NUM_SOURCES-1:0] cfg_enable_data;
  logic                   core_interrupt;
  logic                   isr_ack;
  logic                   isr_return;
  logic                   peripheral_interrupt;
  logic [ISR_WIDTH-1:0]   peripheral_isr_number;
  logic [NUM_SOURCES-1:0] irq_pending;
  logic [NUM_SOURCES-1:0] irq_enable;
  logic                   in_service;

  modport slave (
    input  irq_in, cfg_enable_we, cfg_enable_data, core_interrupt, isr_ack, isr_return,
    output peripheral_interrupt, peripheral_isr_number, irq_pending, irq_enable, in_service
  );

  modport master (
    output irq_in, cfg_enable_we, cfg_enable_data, core_interrupt, isr_ack, isr_return,
    input  peripheral_interrupt, peripheral_isr_number, irq_pending, irq_enable, in_service
  );

endinterface

// File: rtl/w0rm_peripheral_irq_arbiter_priority_encoder.sv
// Fixed-priority encoder: reports whether any request is set and the
// index of the lowest set bit.
module w0rm_irq_priority_encoder
  import w0rm_irq_pkg::*;
#(
  parameter int  NUM_SOURCES = 8,
  localparam int IDX_W       = idx_width(NUM_SOURCES)
) (
  input  logic [NUM_SOURCES-1:0] i_req,
  output logic                   o_any_valid,
  output logic [IDX_W-1:0]       o_index
);

  // NOTE: every output gets a default before the loop, so no latch is inferred.
  always_comb begin
    o_any_valid = |i_req;
    o_index     = '0;
    // Scan downwards so the lowest set bit is the last, winning, assignment.
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (i_req[i]) o_index = IDX_W'(i);
    end
  end

endmodule

// File: rtl/w0rm_peripheral_irq_arbiter.sv
// Peripheral interrupt source for the core controller: latches IRQs, picks the
// lowest eligible source and holds the request until ack, then tracks service.
module w0rm_peripheral_irq_arbiter
  import w0rm_irq_pkg::*;
#(
  parameter int                    NUM_SOURCES = 8,
  parameter int                    ISR_WIDTH   = 8,
  parameter int                    ISR_BASE    = 1,
  parameter logic [NUM_SOURCES-1:0] EDGE_MASK  = '0
) (
  input logic                           clk,
  input logic                           reset,
  w0rm_peripheral_irq_arbiter_if.slave  bus
);

  localparam int IDX_W = idx_width(NUM_SOURCES);

  irq_state_e             r_state;
  irq_state_e             w_state_nxt;
  logic [IDX_W-1:0]       r_sel;
  logic [IDX_W-1:0]       w_sel_nxt;
  logic [NUM_SOURCES-1:0] r_irq_d;
  logic [NUM_SOURCES-1:0] r_pending;
  logic [NUM_SOURCES-1:0] w_pending_nxt;
  logic [NUM_SOURCES-1:0] r_enable;
  logic                   r_core_int_d;
  logic                   r_req;
  logic                   w_req_nxt;
  logic [ISR_WIDTH-1:0]   r_number;
  logic [ISR_WIDTH-1:0]   w_number_nxt;
  logic                   r_in_service;
  logic                   w_in_service_nxt;

  logic [NUM_SOURCES-1:0] w_eligible;
  logic [NUM_SOURCES-1:0] w_rise;
  logic [NUM_SOURCES-1:0] w_clear;
  logic                   w_any;
  logic [IDX_W-1:0]       w_win_idx;
  logic [ISR_WIDTH-1:0]   w_win_vec;
  logic                   w_ack_ok;

  assign w_eligible = r_pending & r_enable;
  assign w_rise     = bus.irq_in & ~r_irq_d;
  assign w_win_vec  = ISR_WIDTH'(ISR_BASE + int'(w_win_idx));

  // An ack while the core's own request was live one cycle earlier answered vector 0.
  assign w_ack_ok   = (r_state == IRQ_REQUEST) && bus.isr_ack && !r_core_int_d;
  assign w_clear    = w_ack_ok ? (NUM_SOURCES'(1) << r_sel) : '0;

  w0rm_irq_priority_encoder #(
    .NUM_SOURCES (NUM_SOURCES)
  ) u_prio (
    .i_req       (w_eligible),
    .o_any_valid (w_any),
    .o_index     (w_win_idx)
  );

  // Edge sources are sticky until acked; a fresh edge beats the clear.
  always_comb begin
    w_pending_nxt = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (EDGE_MASK[i]) w_pending_nxt[i] = w_rise[i] | (r_pending[i] & ~w_clear[i]);
      else              w_pending_nxt[i] = bus.irq_in[i];
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_sel_nxt        = r_sel;
    w_req_nxt        = r_req;
    w_number_nxt     = r_number;
    w_in_service_nxt = r_in_service;
    unique case (r_state)
      IRQ_IDLE: begin
        if (w_any) begin
          w_state_nxt      = IRQ_REQUEST;
          w_sel_nxt        = w_win_idx;
          w_req_nxt        = 1'b1;
          w_number_nxt     = w_win_vec;
          w_in_service_nxt = 1'b0;
        end
      end
      IRQ_REQUEST: begin
        // Selection is frozen here: no re-arbitration and mask writes do not withdraw it.
        if (w_ack_ok) begin
          w_state_nxt      = IRQ_IN_SERVICE;
          w_req_nxt        = 1'b0;
          w_in_service_nxt = 1'b1;
        end
      end
      IRQ_IN_SERVICE: begin
        if (bus.isr_return) begin
          if (w_any) begin
            w_state_nxt      = IRQ_REQUEST;
            w_sel_nxt        = w_win_idx;
            w_req_nxt        = 1'b1;
            w_number_nxt     = w_win_vec;
            w_in_service_nxt = 1'b0;
          end else begin
            w_state_nxt      = IRQ_IDLE;
            w_in_service_nxt = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt      = IRQ_IDLE;
        w_req_nxt        = 1'b0;
        w_in_service_nxt = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IRQ_IDLE;
      r_sel        <= '0;
      r_irq_d      <= '0;
      r_pending    <= '0;
      r_enable     <= '0;
      r_core_int_d <= 1'b0;
      r_req        <= 1'b0;
      r_number     <= ISR_WIDTH'(CORE_ISR_VECTOR);
      r_in_service <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sel        <= w_sel_nxt;
      r_irq_d      <= bus.irq_in;
      r_pending    <= w_pending_nxt;
      if (bus.cfg_enable_we) r_enable <= bus.cfg_enable_data;
      r_core_int_d <= bus.core_interrupt;
      r_req        <= w_req_nxt;
      r_number     <= w_number_nxt;
      r_in_service <= w_in_service_nxt;
    end
  end

  assign bus.peripheral_interrupt  = r_req;
  assign bus.peripheral_isr_number = r_number;
  assign bus.irq_pending           = r_pending;
  assign bus.irq_enable            = r_enable;
  assign bus.in_service            = r_in_service;

endmodule

// File: tb/tb_w0rm_peripheral_irq_arbiter.sv
// Directed bench for the peripheral IRQ arbiter; expected vectors go into a
// scoreboard queue when stimulus is applied and are popped when a request appears.
module tb_w0rm_peripheral_irq_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  w0rm_peripheral_irq_arbiter_if #(.NUM_SOURCES(8), .ISR_WIDTH(8)) bus ();

  w0rm_peripheral_irq_arbiter #(
    .NUM_SOURCES (8),
    .ISR_WIDTH   (8),
    .ISR_BASE    (1),
    .EDGE_MASK   (8'h23)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for a request, then score its vector against the queue head.
  task automatic wait_req(input string tag, input int budget);
    int c;
    logic [7:0] exp_num;
    c = 0;
    while (bus.peripheral_interrupt !== 1'b1 && c < budget) begin
      step(1);
      c++;
    end
    check({tag, "_req"}, 32'(bus.peripheral_interrupt), 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      exp_num = exp_q.pop_front();
      check({tag, "_num"}, 32'(bus.peripheral_isr_number), 32'(exp_num));
    end
  endtask

  task automatic ack_cycle();
    bus.isr_ack = 1'b1;
    step(1);
    bus.isr_ack = 1'b0;
  endtask

  task automatic return_cycle();
    bus.isr_return = 1'b1;
    step(1);
    bus.isr_return = 1'b0;
  endtask

  task automatic write_enable(input logic [7:0] mask);
    bus.cfg_enable_we   = 1'b1;
    bus.cfg_enable_data = mask;
    step(1);
    bus.cfg_enable_we   = 1'b0;
  endtask

  initial begin
    reset               = 1'b1;
    bus.irq_in          = '0;
    bus.cfg_enable_we   = 1'b0;
    bus.cfg_enable_data = '0;
    bus.core_interrupt  = 1'b0;
    bus.isr_ack         = 1'b0;
    bus.isr_return      = 1'b0;
    step(2);
    check("rst_req",     32'(bus.peripheral_interrupt),  32'd0);
    check("rst_num",     32'(bus.peripheral_isr_number), 32'd0);
    check("rst_ins",     32'(bus.in_service),            32'd0);
    check("rst_pending", 32'(bus.irq_pending),           32'd0);
    check("rst_enable",  32'(bus.irq_enable),            32'd0);
    reset = 1'b0;

    // Level source 3: request two cycles after the line rises, ack moves to service.
    write_enable(8'hFF);
    check("t1_enable", 32'(bus.irq_enable), 32'hFF);
    bus.irq_in = 8'h08;
    exp_q.push_back(8'd4);
    step(1);
    check("t1_pending", 32'(bus.irq_pending), 32'h08);
    check("t1_req_early", 32'(bus.peripheral_interrupt), 32'd0);
    wait_req("t1", 1);
    ack_cycle();
    check("t1_ack_req", 32'(bus.peripheral_interrupt), 32'd0);
    check("t1_ack_ins", 32'(bus.in_service), 32'd1);
    exp_q.push_back(8'd4);
    return_cycle();
    wait_req("t1_relevel", 0);
    check("t1_relevel_ins", 32'(bus.in_service), 32'd0);
    bus.irq_in = 8'h00;
    ack_cycle();
    return_cycle();
    check("t1_idle_req", 32'(bus.peripheral_interrupt), 32'd0);
    check("t1_idle_ins", 32'(bus.in_service), 32'd0);

    // Edge sources 1 and 5 together: 1 wins, 5 follows straight from service.
    bus.irq_in = 8'h22;
    exp_q.push_back(8'd2);
    exp_q.push_back(8'd6);
    step(1);
    bus.irq_in = 8'h00;
    check("t2_pending", 32'(bus.irq_pending), 32'h22);
    wait_req("t2_a", 1);
    ack_cycle();
    check("t2_clr_pending", 32'(bus.irq_pending), 32'h20);
    check("t2_ins", 32'(bus.in_service), 32'd1);
    return_cycle();
    wait_req("t2_b", 0);
    check("t2_b_ins", 32'(bus.in_service), 32'd0);
    ack_cycle();
    check("t2_b_pending", 32'(bus.irq_pending), 32'h00);
    return_cycle();
    check("t2_idle_req", 32'(bus.peripheral_interrupt), 32'd0);

    // Ack following a core_interrupt cycle belongs to vector 0 and is ignored.
    bus.irq_in = 8'h04;
    exp_q.push_back(8'd3);
    step(1);
    wait_req("t3", 1);
    bus.core_interrupt = 1'b1;
    step(1);
    bus.core_interrupt = 1'b0;
    ack_cycle();
    check("t3_ign_req", 32'(bus.peripheral_interrupt), 32'd1);
    check("t3_ign_ins", 32'(bus.in_service), 32'd0);
    check("t3_ign_num", 32'(bus.peripheral_isr_number), 32'd3);
    ack_cycle();
    check("t3_acc_req", 32'(bus.peripheral_interrupt), 32'd0);
    check("t3_acc_ins", 32'(bus.in_service), 32'd1);

    // Masking source 2 while it is presented keeps the request; no re-request after.
    exp_q.push_back(8'd3);
    return_cycle();
    wait_req("t4", 0);
    write_enable(8'hFB);
    check("t4_held_req", 32'(bus.peripheral_interrupt), 32'd1);
    check("t4_held_num", 32'(bus.peripheral_isr_number), 32'd3);
    check("t4_enable", 32'(bus.irq_enable), 32'hFB);
    ack_cycle();
    return_cycle();
    check("t4_ret_ins", 32'(bus.in_service), 32'd0);
    step(3);
    check("t4_no_rereq", 32'(bus.peripheral_interrupt), 32'd0);
    check("t4_pending", 32'(bus.irq_pending), 32'h04);
    bus.irq_in = 8'h00;
    write_enable(8'hFF);
    step(1);
    check("t4_clean_req", 32'(bus.peripheral_interrupt), 32'd0);

    // Edge on source 0 coincides with its ack clear: pending survives.
    bus.irq_in = 8'h01;
    exp_q.push_back(8'd1);
    step(1);
    bus.irq_in = 8'h00;
    wait_req("t5_a", 1);
    bus.irq_in = 8'h01;
    ack_cycle();
    bus.irq_in = 8'h00;
    check("t5_keep_pending", 32'(bus.irq_pending), 32'h01);
    check("t5_ins", 32'(bus.in_service), 32'd1);
    exp_q.push_back(8'd1);
    return_cycle();
    wait_req("t5_b", 0);
    ack_cycle();
    check("t5_clr_pending", 32'(bus.irq_pending), 32'h00);
    return_cycle();
    check("t5_idle_req", 32'(bus.peripheral_interrupt), 32'd0);

    // Reset during service with a live level IRQ, then re-request after release.
    bus.irq_in = 8'h08;
    exp_q.push_back(8'd4);
    step(1);
    wait_req("t6_a", 1);
    ack_cycle();
    check("t6_pre_ins", 32'(bus.in_service), 32'd1);
    reset = 1'b1;
    step(1);
    check("t6_rst_req",     32'(bus.peripheral_interrupt),  32'd0);
    check("t6_rst_num",     32'(bus.peripheral_isr_number), 32'd0);
    check("t6_rst_ins",     32'(bus.in_service),            32'd0);
    check("t6_rst_pending", 32'(bus.irq_pending),           32'd0);
    check("t6_rst_enable",  32'(bus.irq_enable),            32'd0);
    step(1);
    reset = 1'b0;
    exp_q.push_back(8'd4);
    write_enable(8'hFF);
    check("t6_rel_req", 32'(bus.peripheral_interrupt), 32'd0);
    wait_req("t6_b", 1);
    return_cycle();
    check("t6_ret_ignored", 32'(bus.peripheral_interrupt), 32'd1);
    bus.irq_in = 8'h00;
    step(1);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
